// File: rtl/truth_table_scanner_pkg.sv
// truth_table_scanner_pkg: shared state encoding and scan constants
package truth_table_scanner_pkg;
   localparam int NVEC = 16;
   localparam int IDXW = 4;
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/truth_table_scanner_capture.sv
// tt_capture: one captured truth table and its running ones count
module tt_capture
   import truth_table_scanner_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            en,
   input  logic [IDXW-1:0] idx,
   input  logic            din,
   output logic [NVEC-1:0] map,
   output logic [IDXW:0]   cnt
);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         map <= '0;
         cnt <= '0;
      end else if (clear) begin
         map <= '0;
         cnt <= '0;
      end else if (en) begin
         map[idx] <= din;
         cnt      <= cnt + (IDXW+1)'(din);
      end
endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks all 16 input vectors and captures three external 4-input functions
module truth_table_scanner
   import truth_table_scanner_pkg::*;
#(
   parameter int SETTLE = 0
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            x,
   output logic            y,
   output logic            w,
   output logic            z,
   input  logic            c_in,
   input  logic            d_in,
   input  logic            e_in,
   output logic            busy,
   output logic            done,
   output logic [NVEC-1:0] c_map,
   output logic [NVEC-1:0] d_map,
   output logic [NVEC-1:0] e_map,
   output logic [IDXW:0]   c_cnt,
   output logic [IDXW:0]   d_cnt,
   output logic [IDXW:0]   e_cnt
);
   state_t          state, state_n;
   logic [IDXW-1:0] idx, idx_n, vec;
   logic [3:0]      settle, settle_n;
   logic            clear, en;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         settle <= '0;
         vec    <= '0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         settle <= settle_n;
         vec    <= (state_n == DRIVE || state_n == SAMPLE) ? idx_n : '0;
      end
   always_comb begin
      state_n  = state;
      idx_n    = idx;
      settle_n = settle;
      clear    = 1'b0;
      en       = 1'b0;
      case (state)
         IDLE:
            if (start) begin
               state_n  = DRIVE;
               idx_n    = '0;
               settle_n = 4'(SETTLE);
               clear    = 1'b1;
            end
         DRIVE: begin
            state_n  = (settle == '0) ? SAMPLE : DRIVE;
            settle_n = (settle == '0) ? settle : settle - 4'd1;
         end
         SAMPLE: begin
            en = 1'b1;
            // last vector exits to DONE; idx never wraps back to 0 mid-scan
            if (idx == IDXW'(NVEC-1))
               state_n = DONE;
            else begin
               state_n  = DRIVE;
               idx_n    = idx + 1'b1;
               settle_n = 4'(SETTLE);
            end
         end
         default: state_n = IDLE;
      endcase
   end
   assign {x, y, w, z} = vec;
   assign busy = (state == DRIVE) || (state == SAMPLE);
   assign done = (state == DONE);
   tt_capture u_c (.clk(clk), .rst(rst), .clear(clear), .en(en), .idx(idx), .din(c_in), .map(c_map), .cnt(c_cnt));
   tt_capture u_d (.clk(clk), .rst(rst), .clear(clear), .en(en), .idx(idx), .din(d_in), .map(d_map), .cnt(d_cnt));
   tt_capture u_e (.clk(clk), .rst(rst), .clear(clear), .en(en), .idx(idx), .din(e_in), .map(e_map), .cnt(e_cnt));
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: scoreboard bench for truth_table_scanner
module tb_truth_table_scanner;
   localparam int ST = 3;
   localparam int LAT = 16 * (ST + 2);
   localparam logic [15:0] C_TT = 16'h0EC6;
   localparam logic [15:0] D_TT = 16'h24E5;
   localparam logic [15:0] E_TT = 16'h5A3C;
   typedef struct {
      logic [15:0] c, d, e;
      logic [4:0]  cc, dc, ec;
   } exp_t;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic        x, y, w, z, c_in, d_in, e_in, busy, done;
   logic [15:0] c_map, d_map, e_map;
   logic [4:0]  c_cnt, d_cnt, e_cnt;
   int          mode = 0, checks = 0, failures = 0;
   exp_t        sb[$];
   always #5 clk = ~clk;
   function automatic logic [2:0] model(int m, logic [3:0] v);
      case (m)
         0:       return {C_TT[v], D_TT[v], E_TT[v]};
         1:       return 3'b111;
         2:       return 3'b000;
         default: return {v[0], v[3], v[2] & v[1]};
      endcase
   endfunction
   assign {c_in, d_in, e_in} = model(mode, {x, y, w, z});
   truth_table_scanner #(.SETTLE(ST)) dut (
      .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .w(w), .z(z),
      .c_in(c_in), .d_in(d_in), .e_in(e_in), .busy(busy), .done(done),
      .c_map(c_map), .d_map(d_map), .e_map(e_map),
      .c_cnt(c_cnt), .d_cnt(d_cnt), .e_cnt(e_cnt)
   );
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_zero(string tag);
      chk(tag, {x, y, w, z, busy, done, c_map, d_map, e_map, c_cnt, d_cnt, e_cnt}, 64'h0);
   endtask
   task automatic run_scan(int m, int restart_at);
      exp_t ex;
      logic [2:0] b;
      int n;
      mode = m;
      ex = '{c: '0, d: '0, e: '0, cc: '0, dc: '0, ec: '0};
      for (int i = 0; i < 16; i++) begin
         b = model(m, 4'(i));
         {ex.c[i], ex.d[i], ex.e[i]} = b;
         ex.cc += 5'(b[2]);
         ex.dc += 5'(b[1]);
         ex.ec += 5'(b[0]);
      end
      sb.push_back(ex);
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      chk("busy_after_accept", busy, 1);
      n = 0;
      while (!done && n < 2000) begin
         if (restart_at >= 0 && {x, y, w, z} == 4'(restart_at)) begin
            start = 1'b1;
            restart_at = -1;
         end
         @(posedge clk) #1 start = 1'b0;
         n++;
      end
      chk("latency", n, LAT);
      chk("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
         ex = sb.pop_front();
         chk("c_map", c_map, ex.c);
         chk("d_map", d_map, ex.d);
         chk("e_map", e_map, ex.e);
         chk("counts", {c_cnt, d_cnt, e_cnt}, {ex.cc, ex.dc, ex.ec});
      end
      chk("done_state_vec_busy", {x, y, w, z, busy}, 0);
      @(posedge clk) #1;
      chk("done_one_cycle", done, 0);
      for (int i = 0; i < 5; i++) begin
         chk("idle_no_requeue", {busy, done}, 0);
         chk("maps_hold", {c_map, d_map, e_map}, {ex.c, ex.d, ex.e});
         @(posedge clk) #1;
      end
   endtask
   initial begin
      #2 chk_zero("reset_state");
      @(posedge clk) #1 chk_zero("reset_held_over_edge");
      rst = 1'b0;
      @(posedge clk) #1 chk_zero("idle_after_reset");
      run_scan(0, -1);
      run_scan(1, -1);
      run_scan(2, -1);
      run_scan(0, 5);
      mode = 0;
      sb.push_back('{c: C_TT, d: D_TT, e: E_TT, cc: 5'd7, dc: 5'd7, ec: 5'd8});
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      for (int n = 0; n < 2000 && {x, y, w, z} != 4'd9; n++) @(posedge clk) #1;
      chk("reached_idx9", {x, y, w, z}, 9);
      repeat (ST + 1) @(posedge clk) #1;
      chk("in_sample_idx9", {x, y, w, z, busy}, {4'd9, 1'b1});
      #2 rst = 1'b1;
      #1 chk_zero("async_reset_mid_sample");
      sb.delete();
      @(posedge clk) #1 chk_zero("reset_abort_no_done");
      rst = 1'b0;
      repeat (3) @(posedge clk) #1;
      chk_zero("idle_after_abort");
      run_scan(3, -1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
